// File: rtl/conv_pkg.sv
// Shared types and defaults for the ConvCode encoder chain.
package conv_pkg;

  typedef enum logic {ST_RUN, ST_TAIL} state_e;

  localparam logic [5:0] DEF_GEN_POLY      = 6'b111_101;
  localparam logic [3:0] DEF_PUNCT_PATTERN = 4'b01_11;

  function automatic logic parity(input logic [63:0] vec);
    return ^vec;
  endfunction

endpackage

// File: rtl/conv_gen_parity.sv
// Combinational generator taps: one XOR tree per output bit over {u, sr}, u in the MSB.
module conv_gen_parity
  import conv_pkg::*;
#(
  parameter int                 K        = 3,
  parameter int                 N_OUT    = 2,
  parameter logic [N_OUT*K-1:0] GEN_POLY = DEF_GEN_POLY
) (
  input  logic             u_i,
  input  logic [K-2:0]     sr_i,
  output logic [N_OUT-1:0] code_o
);

  logic [K-1:0] taps;
  assign taps = {u_i, sr_i};

  for (genvar j = 0; j < N_OUT; j++) begin : g_tree
    assign code_o[j] = parity(64'(GEN_POLY[j*K +: K] & taps));
  end

endmodule

// File: rtl/conv_encode_param.sv
// (N_OUT,1,K) zero-tail conv encoder, 1-cycle latency; output register stalls while out_ready_sig is low.
// Define CONV_PUNCTURE_EN to emit per-phase puncture masks instead of all-ones.
module conv_encode_param
  import conv_pkg::*;
#(
  parameter int                            K             = 3,
  parameter int                            N_OUT         = 2,
  parameter logic [N_OUT*K-1:0]            GEN_POLY      = DEF_GEN_POLY,
  parameter int                            PUNCT_PERIOD  = 2,
  parameter logic [N_OUT*PUNCT_PERIOD-1:0] PUNCT_PATTERN = DEF_PUNCT_PATTERN
) (
  input  logic             clk_sig,
  input  logic             reset_sig,
  input  logic             in_valid_sig,
  output logic             in_ready_sig,
  input  logic             in_bit_sig,
  input  logic             in_last_sig,
  output logic             out_valid_sig,
  input  logic             out_ready_sig,
  output logic [N_OUT-1:0] out_code_sig,
  output logic [N_OUT-1:0] out_mask_sig,
  output logic             out_last_sig,
  output logic             busy_sig
);

  localparam int            TW       = $clog2(K);
  localparam logic [TW-1:0] TAIL_END = TW'(K - 2);

  if (K < 2 || N_OUT < 2 || PUNCT_PERIOD < 1 ||
      $bits(PUNCT_PATTERN) != N_OUT * PUNCT_PERIOD) begin : g_bad_param
    $error("conv_encode_param: illegal parameter set");
  end

  state_e           state_q;
  logic [TW-1:0]    tail_cnt_q;
  logic [K-2:0]     sr_q, sr_d;
  logic             out_valid_q, out_last_q;
  logic [N_OUT-1:0] out_code_q, out_mask_q, code_d, mask_d;
  logic             advance, sym_gen, u, last_d;

  assign advance      = !out_valid_q || out_ready_sig;
  assign in_ready_sig = (state_q == ST_RUN) && advance;
  assign sym_gen      = (state_q == ST_RUN) ? (in_valid_sig && in_ready_sig) : advance;
  assign u            = (state_q == ST_RUN) && in_bit_sig;
  assign last_d       = (state_q == ST_TAIL) && (tail_cnt_q == TAIL_END);

  if (K == 2) begin : g_sr1
    assign sr_d = u;
  end else begin : g_srn
    assign sr_d = {u, sr_q[K-2:1]};
  end

  conv_gen_parity #(
    .K        (K),
    .N_OUT    (N_OUT),
    .GEN_POLY (GEN_POLY)
  ) u_parity (
    .u_i    (u),
    .sr_i   (sr_q),
    .code_o (code_d)
  );

`ifdef CONV_PUNCTURE_EN
  localparam int PW = (PUNCT_PERIOD > 1) ? $clog2(PUNCT_PERIOD) : 1;
  logic [PW-1:0] phase_q, phase_d;

  assign mask_d  = PUNCT_PATTERN[phase_q*N_OUT +: N_OUT];
  // Restart the pattern after the final tail symbol so every frame begins at phase 0.
  assign phase_d = (last_d || phase_q == PW'(PUNCT_PERIOD - 1)) ? '0 : phase_q + PW'(1);

  always_ff @(posedge clk_sig or posedge reset_sig) begin
    if (reset_sig) begin
      phase_q <= '0;
    end else if (sym_gen) begin
      phase_q <= phase_d;
    end
  end
`else
  assign mask_d = '1;
`endif

  always_ff @(posedge clk_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state_q     <= ST_RUN;
      tail_cnt_q  <= '0;
      sr_q        <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_mask_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (advance) begin
      // A fully punctured symbol still advances the encoder but is never presented.
      out_valid_q <= sym_gen && (|mask_d);
      out_last_q  <= sym_gen && last_d;
      if (sym_gen) begin
        sr_q       <= sr_d;
        out_code_q <= code_d;
        out_mask_q <= mask_d;
        case (state_q)
          ST_RUN: begin
            if (in_last_sig) begin
              state_q    <= ST_TAIL;
              tail_cnt_q <= '0;
            end
          end
          ST_TAIL: begin
            if (last_d) begin
              state_q    <= ST_RUN;
              tail_cnt_q <= '0;
            end else begin
              tail_cnt_q <= tail_cnt_q + TW'(1);
            end
          end
          default: state_q <= ST_RUN;
        endcase
      end
    end
  end

  assign out_valid_sig = out_valid_q;
  assign out_code_sig  = out_code_q;
  assign out_mask_sig  = out_mask_q;
  assign out_last_sig  = out_last_q;
  assign busy_sig      = (state_q == ST_TAIL) || out_valid_q;

endmodule

// File: tb/tb_conv_encode_param.sv
// Bench for conv_encode_param: default (K=3) and K=4 instances checked against a convolution-sum model.
module tb_conv_encode_param;

  typedef struct packed {
    logic [1:0] code;
    logic [1:0] mask;
    logic       last;
  } sym_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv0, ir0, ib0, il0, ov0, or0, ol0, busy0;
  logic iv1, ir1, ib1, il1, ov1, or1, ol1, busy1;
  logic [1:0] oc0, om0, oc1, om1;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   bp_mode = 0;
  sym_t q0[$], q1[$], exp0[$], exp1[$];
  int   c0[$];

  conv_encode_param dut0 (
    .clk_sig(clk), .reset_sig(rst),
    .in_valid_sig(iv0), .in_ready_sig(ir0), .in_bit_sig(ib0), .in_last_sig(il0),
    .out_valid_sig(ov0), .out_ready_sig(or0), .out_code_sig(oc0), .out_mask_sig(om0),
    .out_last_sig(ol0), .busy_sig(busy0)
  );

  conv_encode_param #(.K(4), .N_OUT(2), .GEN_POLY(8'b1111_1101)) dut1 (
    .clk_sig(clk), .reset_sig(rst),
    .in_valid_sig(iv1), .in_ready_sig(ir1), .in_bit_sig(ib1), .in_last_sig(il1),
    .out_valid_sig(ov1), .out_ready_sig(or1), .out_code_sig(oc1), .out_mask_sig(om1),
    .out_last_sig(ol1), .busy_sig(busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (bp_mode == 0) begin
      or0 = 1'b1; or1 = 1'b1;
    end else if (bp_mode == 1) begin
      or0 = 1'($urandom_range(0, 1)); or1 = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (ov0 && or0) begin q0.push_back(sym_t'({oc0, om0, ol0})); c0.push_back(cyc); end
      if (ov1 && or1) q1.push_back(sym_t'({oc1, om1, ol1}));
    end
  end

  // Reference: symbol t, bit j = XOR_i gen_j[K-1-i] & u[t-i], u zero outside the frame.
  task automatic model_frame(input int sel, input logic [31:0] bits, input int len);
    int k;
    logic [31:0] gp;
    logic p, ui;
    sym_t s;
`ifdef CONV_PUNCTURE_EN
    logic [3:0] pat;
    pat = 4'b01_11;
`endif
    k  = (sel == 0) ? 3 : 4;
    gp = (sel == 0) ? 32'b111_101 : 32'b1111_1101;
    for (int t = 0; t < len + k - 1; t++) begin
      s = '0;
      for (int j = 0; j < 2; j++) begin
        p = 1'b0;
        for (int i = 0; i < k; i++) begin
          ui = (t - i >= 0 && t - i < len) ? bits[t-i] : 1'b0;
          p ^= gp[j*k + (k-1-i)] & ui;
        end
        s.code[j] = p;
      end
`ifdef CONV_PUNCTURE_EN
      s.mask = pat[(t % 2)*2 +: 2];
`else
      s.mask = 2'b11;
`endif
      s.last = (t == len + k - 2);
      if (sel == 0) exp0.push_back(s); else exp1.push_back(s);
    end
  endtask

  task automatic set_in(input int sel, input logic v, input logic b, input logic l);
    if (sel == 0) begin iv0 = v; ib0 = b; il0 = l; end
    else begin iv1 = v; ib1 = b; il1 = l; end
  endtask

  task automatic send_frame(input int sel, input logic [31:0] bits, input int len,
                            input int gap_min, input int gap_max, input logic last_en);
    logic acc;
    int n, gap;
    for (int b = 0; b < len; b++) begin
      set_in(sel, 1'b1, bits[b], last_en && (b == len - 1));
      acc = 1'b0;
      n = 0;
      while (!acc && n < 200) begin
        @(negedge clk);
        acc = (sel == 0) ? (iv0 && ir0) : (iv1 && ir1);
        @(posedge clk); #1;
        n++;
      end
      checks++;
      if (!acc) begin
        errors++;
        $display("FAIL accept_timeout: dut%0d bit %0d not accepted, waited %0d cycles (limit 200)", sel, b, n);
      end
      set_in(sel, 1'b0, 1'b0, 1'b0);
      gap = $urandom_range(gap_max, gap_min);
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_syms(input int sel, input int n);
    int c = 0;
    while (((sel == 0) ? q0.size() : q1.size()) < n && c < 2000) begin @(posedge clk); c++; end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    q0.delete(); q1.delete(); exp0.delete(); exp1.delete(); c0.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ov0, oc0, om0, ol0, busy0} !== 7'd0) begin
      errors++; $display("FAIL reset_dut0: outputs %b required 0000000", {ov0, oc0, om0, ol0, busy0});
    end
    checks++;
    if ({ov1, oc1, om1, ol1, busy1} !== 7'd0) begin
      errors++; $display("FAIL reset_dut1: outputs %b required 0000000", {ov1, oc1, om1, ol1, busy1});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ir0, ir1} !== 2'b11) begin
      errors++; $display("FAIL reset_in_ready: got %b required 11", {ir0, ir1});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [1:0] tbl [6];
    tbl = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    clear_all();
    bp_mode = 0;
    model_frame(0, 32'b1101, 4);
    send_frame(0, 32'b1101, 4, 0, 0, 1'b1);
    wait_syms(0, 6);
    checks++;
    if (q0.size() !== 6) begin errors++; $display("FAIL basic_count: got %0d required 6", q0.size()); end
    for (int i = 0; i < 6 && i < q0.size(); i++) begin
      checks++;
      if (q0[i].code !== tbl[i] || q0[i] !== exp0[i]) begin
        errors++;
        $display("FAIL basic_sym%0d: got code=%b mask=%b last=%b required code=%b mask=%b last=%b",
                 i, q0[i].code, q0[i].mask, q0[i].last, tbl[i], exp0[i].mask, exp0[i].last);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    clear_all();
    bp_mode = 2;
    or0 = 1'b1;
    model_frame(0, 32'b1101, 4);
    fork
      send_frame(0, 32'b1101, 4, 0, 0, 1'b1);
      begin
        n = 0;
        while (q0.size() < 1 && n < 100) begin @(posedge clk); n++; end
        #1;
        or0 = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          checks++;
          if ({ov0, oc0, ir0} !== {1'b1, 2'b10, 1'b0}) begin
            errors++;
            $display("FAIL stall_cycle%0d: valid/code/in_ready %b required 1_10_0", s, {ov0, oc0, ir0});
          end
          @(posedge clk);
        end
        #1;
        or0 = 1'b1;
      end
    join
    wait_syms(0, 6);
    bp_mode = 0;
    checks++;
    if (q0.size() !== exp0.size()) begin errors++; $display("FAIL stall_count: got %0d required %0d", q0.size(), exp0.size()); end
    for (int i = 0; i < exp0.size() && i < q0.size(); i++) begin
      checks++;
      if (q0[i] !== exp0[i]) begin
        errors++; $display("FAIL stall_sym%0d: got %b required %b", i, q0[i], exp0[i]);
      end
    end
  endtask

  task automatic test_gaps();
    clear_all();
    bp_mode = 0;
    model_frame(0, 32'b1101, 4);
    send_frame(0, 32'b1101, 4, 2, 2, 1'b1);
    wait_syms(0, 6);
    checks++;
    if (q0.size() !== exp0.size()) begin errors++; $display("FAIL gaps_count: got %0d required %0d", q0.size(), exp0.size()); end
    for (int i = 0; i < exp0.size() && i < q0.size(); i++) begin
      checks++;
      if (q0[i] !== exp0[i]) begin
        errors++; $display("FAIL gaps_sym%0d: got %b required %b", i, q0[i], exp0[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] tbl [4];
    tbl = '{2'b11, 2'b01, 2'b01, 2'b11};
    clear_all();
    bp_mode = 2;
    or0 = 1'b1;
    send_frame(0, 32'b01, 2, 0, 0, 1'b0);
    or0 = 1'b0;
    @(negedge clk);
    checks++;
    if (ov0 !== 1'b1) begin errors++; $display("FAIL midreset_pending: out_valid %b required 1", ov0); end
    rst = 1'b1;
    #1;
    checks++;
    if ({ov0, oc0, om0, ol0, busy0} !== 7'd0) begin
      errors++; $display("FAIL midreset_outputs: got %b required 0000000", {ov0, oc0, om0, ol0, busy0});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    or0 = 1'b1;
    bp_mode = 0;
    clear_all();
    model_frame(0, 32'b11, 2);
    send_frame(0, 32'b11, 2, 0, 0, 1'b1);
    wait_syms(0, 4);
    checks++;
    if (q0.size() !== 4) begin errors++; $display("FAIL midreset_count: got %0d required 4", q0.size()); end
    for (int i = 0; i < 4 && i < q0.size(); i++) begin
      checks++;
      if (q0[i].code !== tbl[i] || q0[i] !== exp0[i]) begin
        errors++; $display("FAIL midreset_sym%0d: got %b required code=%b full=%b", i, q0[i], tbl[i], exp0[i]);
      end
    end
  endtask

  task automatic test_k4();
    clear_all();
    bp_mode = 0;
    model_frame(1, 32'b1, 1);
    send_frame(1, 32'b1, 1, 0, 0, 1'b1);
    wait_syms(1, 4);
    checks++;
    if (q1.size() !== 4) begin errors++; $display("FAIL k4_count: got %0d required 4", q1.size()); end
    for (int i = 0; i < exp1.size() && i < q1.size(); i++) begin
      checks++;
      if (q1[i] !== exp1[i]) begin
        errors++; $display("FAIL k4_sym%0d: got %b required %b", i, q1[i], exp1[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_all();
    bp_mode = 0;
    model_frame(0, 32'b101, 3);
    model_frame(0, 32'b10, 2);
    send_frame(0, 32'b101, 3, 0, 0, 1'b1);
    send_frame(0, 32'b10, 2, 0, 0, 1'b1);
    wait_syms(0, 9);
    checks++;
    if (q0.size() !== 9) begin errors++; $display("FAIL b2b_count: got %0d required 9", q0.size()); end
    for (int i = 0; i < exp0.size() && i < q0.size(); i++) begin
      checks++;
      if (q0[i] !== exp0[i]) begin
        errors++; $display("FAIL b2b_sym%0d: got %b required %b", i, q0[i], exp0[i]);
      end
    end
    if (c0.size() == 9) begin
      checks++;
      if (c0[8] - c0[0] !== 8) begin
        errors++; $display("FAIL b2b_gapless: span %0d cycles required 8", c0[8] - c0[0]);
      end
    end
  endtask

  task automatic test_random(input int sel);
    int len;
    logic [31:0] bits;
    clear_all();
    bp_mode = 1;
    for (int f = 0; f < 6; f++) begin
      len  = $urandom_range(10, 1);
      bits = $urandom;
      model_frame(sel, bits, len);
      send_frame(sel, bits, len, 0, 2, 1'b1);
    end
    wait_syms(sel, (sel == 0) ? exp0.size() : exp1.size());
    bp_mode = 0;
    if (sel == 0) begin
      checks++;
      if (q0.size() !== exp0.size()) begin errors++; $display("FAIL rand0_count: got %0d required %0d", q0.size(), exp0.size()); end
      for (int i = 0; i < exp0.size() && i < q0.size(); i++) begin
        checks++;
        if (q0[i] !== exp0[i]) begin errors++; $display("FAIL rand0_sym%0d: got %b required %b", i, q0[i], exp0[i]); end
      end
    end else begin
      checks++;
      if (q1.size() !== exp1.size()) begin errors++; $display("FAIL rand1_count: got %0d required %0d", q1.size(), exp1.size()); end
      for (int i = 0; i < exp1.size() && i < q1.size(); i++) begin
        checks++;
        if (q1[i] !== exp1[i]) begin errors++; $display("FAIL rand1_sym%0d: got %b required %b", i, q1[i], exp1[i]); end
      end
    end
  endtask

  initial begin
    iv0 = 1'b0; ib0 = 1'b0; il0 = 1'b0; or0 = 1'b1;
    iv1 = 1'b0; ib1 = 1'b0; il1 = 1'b0; or1 = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_k4();
    test_back_to_back();
    test_random(0);
    test_random(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
